key_inject_sched: RTL
=====================

Name: key_inject_sched

Overview:
- Single owner of the keyboard-matrix event port (strobe, code, release) feeding the PS/2-to-Spectrum matrix converter.
- Arbitrates between two event sources:
  - live PS/2 events from the HPS `ps2_key` bus;
  - a macro (auto-type) player that steps through a 9-bit event RAM.
- Live events arriving during macro playback are buffered, not lost, and drain when the macro finishes.
- Macro timing is a programmable step interval.

Parameters:
- STEP_TICKS, 7000000, clk_sys cycles between consecutive macro entries.
- FIFO_DEPTH, 4, live-event buffer depth; power of two, at least 2.
- ADDR_W, 6, macro RAM address width.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  66  HPS keyboard bus; bit 64 toggles once per event.
- macro_start  in  1  pulse; starts playback at address 0.
- macro_abort  in  1  pulse; stops playback.
- macro_addr  out  ADDR_W  macro RAM read address.
- macro_data  in  9  RAM word {release, code}; valid 1 cycle after macro_addr.
- key_stb  out  1  one-cycle event strobe to the matrix converter.
- key_code  out  8  scancode (extension bit dropped).
- key_release  out  1  1 = key up.
- busy  out  1  macro playback active.
- ovf  out  1  one-cycle pulse when a live event is dropped.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM in IDLE, step counter 0, held flag 0.
- Live decode, every cycle: event when ps2_key[64] differs from its registered copy.
  - pressed = (ps2_key[15:8] != 8'hF0).
  - code = ps2_key[7:0], forced to 0 when ps2_key[63:24] != 0 (PRNSCR/PAUSE filtered).
  - Entry pushed = {~pressed, code}.
  - Code-0 entries are still pushed and forwarded; the converter ignores them.
- FIFO:
  - Push on a live event.
  - When full, drop the new event and pulse ovf the same cycle as detection.
  - Simultaneous push and pop when full is allowed: the pop frees the slot, no ovf.
- FSM states: IDLE, FETCH, WAIT, EMIT, STEP, ABORT_REL.
  - IDLE: busy=0.
    - FIFO non-empty: pop and drive key_stb=1 with the popped fields next cycle. Latency push→strobe is 2 cycles with an empty FIFO.
    - macro_start takes priority over a pop in the same cycle: macro_addr=0 → FETCH.
  - FETCH: one cycle, address presented → WAIT.
  - WAIT: data captured → EMIT.
  - EMIT: decode captured word.
    - 9'h1FF (end marker): → IDLE. If a macro key is still held, go via ABORT_REL instead.
    - 9'h000 (pause): no strobe → STEP.
    - Otherwise: key_stb=1, key_code/key_release from the word.
      - Held flag: press sets it and records the code; release of the recorded code clears it.
      - → STEP.
  - STEP: counter counts to STEP_TICKS-1, then clears, increments macro_addr → FETCH.
    - Address wrap at 2^ADDR_W-1 ends playback (same handling as the end marker).
  - ABORT_REL: if held, emit one release strobe for the recorded code; clear held → IDLE.
- macro_abort in any non-IDLE state → ABORT_REL the next cycle. If it coincides with an EMIT strobe, the strobe still issues and ABORT_REL follows.
- macro_start while busy is ignored.
- busy=1 from the cycle after macro_start until IDLE is re-entered.
- Live events are never forwarded while busy; FIFO drain resumes in IDLE, one event per cycle.
- key_stb never asserts on two consecutive cycles from different sources.
- key_code and key_release hold their last values when key_stb=0.
- Reset assertion mid-macro: immediate return to IDLE, no release emitted; the converter is reset by the same reset.

Decomposition:
- Package kbd_pkg:
  - 9-bit macro word typedef {release, code}.
  - Constants MACRO_END=9'h1FF, MACRO_PAUSE=9'h000, SC_BREAK=8'hF0, SC_EXT=8'hE0.
  - FSM state enum.
- Sub-module key_evt_fifo: parameterised synchronous FIFO, 9-bit entries, full/empty flags, reset_n. Instantiated once for the live buffer.

Test Plan (STEP_TICKS=4 for sim):
- Toggle ps2_key[64] with [15:0]=16'h001C, idle → key_stb 2 cycles later, key_code=8'h1C, key_release=0; then [15:0]=16'hF01C → key_release=1.
- ps2_key[63:24] nonzero (PRNSCR) → strobe with key_code=8'h00.
- Macro RAM {0_3B, 1_3B, 000, 0_5A, 1_5A, 1FF}, macro_start →
  - strobes 3B press, 3B release, 5A press, 5A release;
  - adjacent entries 7 cycles apart (FETCH+WAIT+EMIT+4); pause gap 14 cycles;
  - busy falls after 1FF.
- During that macro, 6 live events with FIFO_DEPTH=4 → 2 ovf pulses; 4 events emitted in order on consecutive cycles after busy falls.
- Abort after the 0_5A strobe → exactly one extra strobe, code 5A with release=1; then busy=0.
- Assert reset_n=0 mid-STEP → outputs 0 immediately. Release reset, pulse macro_start → playback restarts from address 0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event scheduler.
// Macro words and live FIFO entries share one {rel, code} layout.
package kbd_pkg;

  typedef struct packed {
    logic       rel;
    logic [7:0] code;
  } macro_word_t;

  localparam logic [8:0] MACRO_END   = 9'h1FF;
  localparam logic [8:0] MACRO_PAUSE = 9'h000;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_STEP,
    ST_ABORT_REL
  } state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous FIFO of {rel, code} entries; head is readable combinationally, 1-cycle write-to-visible.
// Pushes while full are ignored unless a pop frees the slot in the same cycle.
module key_evt_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        push,
  input  macro_word_t push_dat,
  input  logic        pop,
  output macro_word_t pop_dat,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  macro_word_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/key_inject_sched.sv
// Arbitrates live PS/2 events and macro playback onto one key event port; live push->strobe 2 cycles.
// Live events buffer in a FIFO while a macro plays; overflow drops the new event and pulses ovf.
module key_inject_sched
  import kbd_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 7000000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [65:0]       ps2_key,
  input  logic              macro_start,
  input  logic              macro_abort,
  output logic [ADDR_W-1:0] macro_addr,
  input  logic [8:0]        macro_data,
  output logic              key_stb,
  output logic [7:0]        key_code,
  output logic              key_release,
  output logic              busy,
  output logic              ovf
);

  localparam int CNT_W = $clog2(STEP_TICKS + 1);

  state_t             state;
  logic               tog_q;
  logic               live_evt;
  macro_word_t        live_word;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  macro_word_t        fifo_head;
  macro_word_t        mword;
  logic [CNT_W-1:0]   step_cnt;
  logic               held;
  logic [7:0]         held_code;
  logic               stb_macro;
  logic               unused_bits;

  assign live_evt    = ps2_key[64] ^ tog_q;
  assign live_word   = {(ps2_key[15:8] == SC_BREAK),
                        ((ps2_key[63:24] != '0) ? 8'h00 : ps2_key[7:0])};
  assign unused_bits = ^{ps2_key[65], ps2_key[23:16]};

  // A pop straight after a macro strobe would put two sources back to back.
  assign fifo_pop = (state == ST_IDLE) && !macro_start && !fifo_empty && !(key_stb && stb_macro);
  assign ovf      = live_evt && fifo_full && !fifo_pop;

  key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_live_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push     (live_evt),
    .push_dat (live_word),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tog_q <= 1'b0;
    else          tog_q <= ps2_key[64];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      macro_addr  <= '0;
      mword       <= '0;
      step_cnt    <= '0;
      held        <= 1'b0;
      held_code   <= '0;
      key_stb     <= 1'b0;
      key_code    <= '0;
      key_release <= 1'b0;
      busy        <= 1'b0;
      stb_macro   <= 1'b0;
    end else begin
      key_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (macro_start) begin
            macro_addr <= '0;
            step_cnt   <= '0;
            busy       <= 1'b1;
            state      <= ST_FETCH;
          end else if (fifo_pop) begin
            key_stb     <= 1'b1;
            key_code    <= fifo_head.code;
            key_release <= fifo_head.rel;
            stb_macro   <= 1'b0;
          end
        end
        ST_FETCH: state <= macro_abort ? ST_ABORT_REL : ST_WAIT;
        ST_WAIT: begin
          mword <= macro_data;
          state <= macro_abort ? ST_ABORT_REL : ST_EMIT;
        end
        ST_EMIT: begin
          if (mword == MACRO_END) begin
            if (held) state <= ST_ABORT_REL;
            else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (mword == MACRO_PAUSE) begin
            state <= ST_STEP;
          end else begin
            key_stb     <= 1'b1;
            key_code    <= mword.code;
            key_release <= mword.rel;
            stb_macro   <= 1'b1;
            if (!mword.rel) begin
              held      <= 1'b1;
              held_code <= mword.code;
            end else if (mword.code == held_code) begin
              held <= 1'b0;
            end
            state <= ST_STEP;
          end
          if (macro_abort) state <= ST_ABORT_REL;
        end
        ST_STEP: begin
          if (macro_abort) begin
            state <= ST_ABORT_REL;
          end else if (step_cnt == CNT_W'(STEP_TICKS - 1)) begin
            step_cnt <= '0;
            // Running off the top of the RAM ends playback like an end marker.
            if (macro_addr == '1) begin
              if (held) state <= ST_ABORT_REL;
              else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              macro_addr <= macro_addr + 1'b1;
              state      <= ST_FETCH;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        ST_ABORT_REL: begin
          if (held) begin
            key_stb     <= 1'b1;
            key_code    <= held_code;
            key_release <= 1'b1;
            stb_macro   <= 1'b1;
          end
          held     <= 1'b0;
          step_cnt <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
